cnn_pingpong_ram: RTL and testbench
===================================

# cnn_pingpong_ram

Parametrised two-bank (ping-pong) multi-channel feature-map buffer for the CNN datapath. It replaces the single-port-pair pixel store with a version that holds one bank for the producing layer and one for the consuming layer. Bank ownership is handed over with explicit commit/release handshakes. The block has CH parallel lanes, per-lane write masking, configurable read latency and address-range error detection.

## Interface
- DATA_W, 16, width of one channel word (signed)
- CH, 4, number of parallel channel lanes
- DEPTH, 1024, words per lane per bank
- ADDR_W, 10, address width; DEPTH <= 2**ADDR_W
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address within current write bank
- wr_data  in  CH*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- wr_mask  in  CH  lane k written only if wr_mask[k]=1
- wr_last  in  1  commit current write bank; sampled only with an accepted write
- wr_ready  out  1  current write bank is FREE
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address within current read bank
- rd_release  in  1  reader finished with current read bank
- rd_avail  out  1  current read bank is FULL
- rd_data  out  CH*DATA_W  read data, same lane packing
- rd_valid  out  1  rd_data valid this cycle
- full_cnt  out  2  number of FULL banks (0..2)
- err  out  1  sticky out-of-range access flag

## Operation
- State: bank_st[0..1] in {FREE, FULL}; write pointer wb; read pointer rb.
- Reset (async assert, synchronous-effect deassert):
  - bank_st = FREE, FREE; wb = rb = 0.
  - wr_ready = 1, rd_avail = 0, rd_valid = 0, rd_data = 0, full_cnt = 0, err = 0.
  - Read pipeline flushed. Memory contents are not cleared.
- Write acceptance: wr_en & wr_ready.
  - Writes mem[wb][k][wr_addr] = lane k for every k with wr_mask[k]=1.
  - wr_en while wr_ready=0 is ignored entirely, including wr_last.
- Commit: accepted write with wr_last=1 → bank_st[wb] = FULL, wb toggles. The last word itself is written.
- Read acceptance: rd_en & rd_avail reads mem[rb][*][rd_addr]. rd_en while rd_avail=0 is ignored and produces no rd_valid.
- Release: rd_release & rd_avail → bank_st[rb] = FREE, rb toggles. rd_release while rd_avail=0 is ignored.
  - A read accepted in the release cycle completes normally with old-bank data.
- Simultaneous commit and release: always on different banks; both take effect in the same cycle.
- Flags: wr_ready = (bank_st[wb]==FREE), rd_avail = (bank_st[rb]==FULL), full_cnt = count of FULL banks. All three are registered from the next state.
- Range check:
  - Write with wr_addr >= DEPTH: no lane written, err set. Commit still occurs if wr_last=1.
  - Read with rd_addr >= DEPTH: rd_valid still asserted, rd_data = 0, err set.
  - err clears only on reset.

## Timing
- Accepted read at cycle t:
  - RD_LAT=1: rd_valid=1 and rd_data at t+1.
  - RD_LAT=2: output register stage, valid at t+2.
- Fully pipelined: one read accepted per cycle.
- rd_data holds its last value while rd_valid=0.
- Commit at t: rd_avail can rise at t+1 (if rb points to that bank); full_cnt updates at t+1.
- Release at t: wr_ready can rise at t+1; full_cnt updates at t+1.
- Read-after-write through the handshake: earliest read of a committed bank is accepted at t+1 and returns data written up to and including t.
- No read/write collision on the same bank: ownership is exclusive by construction.
- Reset mid-operation: in-flight rd_valid is dropped immediately; both banks become FREE.
- Throughput: writer never stalls while the reader releases a bank before the writer finishes the other.

## Test plan
- Reset, then check outputs: wr_ready=1, rd_avail=0, full_cnt=0, err=0, rd_valid=0. Then rd_en=1, rd_release=1 → no rd_valid, state unchanged.
- Single bank (CH=4, DATA_W=16):
  - Write addr 0..7 with lane k = 16'h100*k+addr, wr_last on addr 7 → rd_avail=1 next cycle, full_cnt=1.
  - Read 0..7 back-to-back → rd_valid continuous; data matches at t+RD_LAT, checked for RD_LAT=1 and 2.
- Mask: write addr 3 with mask 4'b0101 over prior value 16'hAAAA in all lanes, new data 16'h5555 → lanes 0 and 2 read 16'h5555; lanes 1 and 3 read 16'hAAAA.
- Ping-pong:
  - Fill bank 0, fill bank 1 → full_cnt=2, wr_ready=0; a third write is ignored.
  - rd_release → wr_ready=1 next cycle, rb=1. Read returns bank-1 data.
  - Same-cycle commit and release → full_cnt unchanged.
- Range: wr_addr=DEPTH → err=1, no lane changed. rd_addr=DEPTH+5 → rd_valid=1, rd_data=0, err stays 1.
- Reset mid-stream: assert rst_n=0 while rd_valid=1 with full_cnt=2 → outputs return to reset values asynchronously; after deassert, wr_ready=1.

Source files
------------

// File: rtl/cnn_pingpong_ram.sv
// Two-bank ping-pong feature-map buffer: the producer fills one bank while the consumer drains
// the other, and banks change hands through commit (wr_last) and release (rd_release) handshakes.
module cnn_pingpong_ram #(
    parameter int DATA_W = 16,
    parameter int CH     = 4,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [CH*DATA_W-1:0]   wr_data,
    input  logic [CH-1:0]          wr_mask,
    input  logic                   wr_last,
    output logic                   wr_ready,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   rd_release,
    output logic                   rd_avail,
    output logic [CH*DATA_W-1:0]   rd_data,
    output logic                   rd_valid,
    output logic [1:0]             full_cnt,
    output logic                   err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {FREE = 1'b0, FULL = 1'b1} bank_e;

    bank_e                     bank_st [2];
    bank_e                     bank_st_nxt [2];
    logic                      wb, rb, wb_nxt, rb_nxt;
    logic                      wr_acc, rd_acc, commit, release_acc;
    logic                      wr_oor, rd_oor;
    logic [1:0]                full_cnt_nxt;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic signed [DATA_W-1:0]  mem [2][CH][DEPTH];
    logic signed [DATA_W-1:0]  rd_word_p0 [CH];

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} >= DEPTH_V;
    endfunction

    assign wr_acc      = wr_en & wr_ready;
    assign rd_acc      = rd_en & rd_avail;
    assign commit      = wr_acc & wr_last;
    assign release_acc = rd_release & rd_avail;
    assign wr_oor      = out_of_range(wr_addr);
    assign rd_oor      = out_of_range(rd_addr);
    assign wr_idx      = wr_addr[IDX_W-1:0];
    assign rd_idx      = rd_addr[IDX_W-1:0];

    // Commit and release always target different banks, so both can apply in one cycle.
    always_comb begin
        bank_st_nxt[0] = bank_st[0];
        bank_st_nxt[1] = bank_st[1];
        wb_nxt         = wb;
        rb_nxt         = rb;
        if (commit) begin
            bank_st_nxt[wb] = FULL;
            wb_nxt          = ~wb;
        end
        if (release_acc) begin
            bank_st_nxt[rb] = FREE;
            rb_nxt          = ~rb;
        end
        full_cnt_nxt = {1'b0, bank_st_nxt[0] == FULL} + {1'b0, bank_st_nxt[1] == FULL};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st[0] <= FREE;
            bank_st[1] <= FREE;
            wb         <= 1'b0;
            rb         <= 1'b0;
            wr_ready   <= 1'b1;
            rd_avail   <= 1'b0;
            full_cnt   <= 2'd0;
            err        <= 1'b0;
        end else begin
            bank_st[0] <= bank_st_nxt[0];
            bank_st[1] <= bank_st_nxt[1];
            wb         <= wb_nxt;
            rb         <= rb_nxt;
            wr_ready   <= (bank_st_nxt[wb_nxt] == FREE);
            rd_avail   <= (bank_st_nxt[rb_nxt] == FULL);
            full_cnt   <= full_cnt_nxt;
            err        <= err | (wr_acc & wr_oor) | (rd_acc & rd_oor);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !wr_oor) begin
            for (int k = 0; k < CH; k++) begin
                if (wr_mask[k]) mem[wb][k][wr_idx] <= wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p0: array read; out-of-range reads return zero.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            rd_word_p0[k] = rd_oor ? '0 : mem[rb][k][rd_idx];
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        for (int k = 0; k < CH; k++) rd_data[k*DATA_W +: DATA_W] <= rd_word_p0[k];
                    end
                end
            end
        end else begin : g_lat2
            logic                     vld_p1;
            logic signed [DATA_W-1:0] rd_word_p1 [CH];

            // Stage p1: registered array output.
            always_ff @(posedge clk) begin
                if (rd_acc) begin
                    for (int k = 0; k < CH; k++) rd_word_p1[k] <= rd_word_p0[k];
                end
            end

            // Stage p2: output register, holds while idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p1   <= 1'b0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    vld_p1   <= rd_acc;
                    rd_valid <= vld_p1;
                    if (vld_p1) begin
                        for (int k = 0; k < CH; k++) rd_data[k*DATA_W +: DATA_W] <= rd_word_p1[k];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_cnn_pingpong_ram.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=2 instance share stimulus; a small read-pipeline
// model tracks what each instance must show after every clock edge.
module tb_cnn_pingpong_ram;

    localparam int DATA_W = 16;
    localparam int CH     = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0, wr_last = 1'b0, rd_en = 1'b0, rd_release = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
    logic [63:0]       wr_data = '0;
    logic [3:0]        wr_mask = '0;
    logic              wr_ready1, rd_avail1, rd_valid1, err1;
    logic              wr_ready2, rd_avail2, rd_valid2, err2;
    logic [63:0]       rd_data1, rd_data2;
    logic [1:0]        full_cnt1, full_cnt2;

    int total = 0;
    int bad   = 0;

    logic        m1_v, m2_v, m2p_v;
    logic [63:0] m1_d, m2_d, m2p_d;

    always #5 clk = ~clk;

    cnn_pingpong_ram #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_last(wr_last), .wr_ready(wr_ready1), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_release(rd_release), .rd_avail(rd_avail1), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .full_cnt(full_cnt1), .err(err1));

    cnn_pingpong_ram #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_last(wr_last), .wr_ready(wr_ready2), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_release(rd_release), .rd_avail(rd_avail2), .rd_data(rd_data2),
        .rd_valid(rd_valid2), .full_cnt(full_cnt2), .err(err2));

    function automatic logic [63:0] pat(input logic [15:0] base, input int a);
        logic [63:0] p;
        for (int k = 0; k < CH; k++) p[k*16 +: 16] = base + 16'(16'h100 * k) + 16'(a);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic flags(input logic wr, input logic ra, input logic [1:0] fc, input logic er);
        chk("wr_ready_l1", 64'(wr_ready1), 64'(wr));
        chk("rd_avail_l1", 64'(rd_avail1), 64'(ra));
        chk("full_cnt_l1", 64'(full_cnt1), 64'(fc));
        chk("err_l1",      64'(err1),      64'(er));
        chk("wr_ready_l2", 64'(wr_ready2), 64'(wr));
        chk("rd_avail_l2", 64'(rd_avail2), 64'(ra));
        chk("full_cnt_l2", 64'(full_cnt2), 64'(fc));
        chk("err_l2",      64'(err2),      64'(er));
    endtask

    task automatic chk_rd();
        chk("rd_valid_l1", 64'(rd_valid1), 64'(m1_v));
        chk("rd_data_l1",  rd_data1,       m1_d);
        chk("rd_valid_l2", 64'(rd_valid2), 64'(m2_v));
        chk("rd_data_l2",  rd_data2,       m2_d);
    endtask

    task automatic model_reset();
        m1_v = 1'b0; m2_v = 1'b0; m2p_v = 1'b0;
        m1_d = '0;   m2_d = '0;   m2p_d = '0;
    endtask

    // acc/d: whether the read driven this cycle is accepted and the data it must return
    task automatic cyc(input logic acc, input logic [63:0] d);
        @(posedge clk);
        m1_v = acc;
        if (acc) m1_d = d;
        m2_v = m2p_v;
        if (m2p_v) m2_d = m2p_d;
        m2p_v = acc;
        if (acc) m2p_d = d;
        #1;
        chk_rd();
    endtask

    task automatic set_wr(input logic en, input int a, input logic [63:0] d,
                          input logic [3:0] m, input logic last);
        wr_en = en; wr_addr = ADDR_W'(a); wr_data = d; wr_mask = m; wr_last = last;
    endtask

    task automatic set_rd(input logic en, input int a, input logic rel);
        rd_en = en; rd_addr = ADDR_W'(a); rd_release = rel;
    endtask

    initial begin
        model_reset();
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        flags(1'b1, 1'b0, 2'd0, 1'b0);
        chk_rd();

        // read and release with nothing available are ignored
        set_rd(1, 0, 1); cyc(0, '0);
        set_rd(0, 0, 0); cyc(0, '0);
        flags(1'b1, 1'b0, 2'd0, 1'b0);

        // bank 0: masked word at addr 8, pattern at 0..7, commit on 7
        set_wr(1, 8, {4{16'hAAAA}}, 4'hF, 0);    cyc(0, '0);
        set_wr(1, 8, {4{16'h5555}}, 4'b0101, 0); cyc(0, '0);
        for (int a = 0; a < 8; a++) begin
            set_wr(1, a, pat(16'h0000, a), 4'hF, logic'(a == 7));
            cyc(0, '0);
        end
        set_wr(0, 0, '0, 4'h0, 0);
        flags(1'b1, 1'b1, 2'd1, 1'b0);

        for (int a = 0; a <= 8; a++) begin
            set_rd(1, a, 0);
            cyc(1, (a == 8) ? 64'hAAAA_5555_AAAA_5555 : pat(16'h0000, a));
        end
        set_rd(0, 0, 0); cyc(0, '0); cyc(0, '0);

        // bank 1 fill, then a write with no free bank is ignored
        for (int a = 0; a < 4; a++) begin
            set_wr(1, a, pat(16'h2000, a), 4'hF, logic'(a == 3));
            cyc(0, '0);
        end
        set_wr(0, 0, '0, 4'h0, 0);
        flags(1'b0, 1'b1, 2'd2, 1'b0);
        set_wr(1, 0, {4{16'hDEAD}}, 4'hF, 1); cyc(0, '0);
        set_wr(0, 0, '0, 4'h0, 0);
        flags(1'b0, 1'b1, 2'd2, 1'b0);

        // release bank 0 while reading it, then read bank 1
        set_rd(1, 5, 1); cyc(1, pat(16'h0000, 5));
        set_rd(0, 0, 0);
        flags(1'b1, 1'b1, 2'd1, 1'b0);
        set_rd(1, 0, 0); cyc(1, pat(16'h2000, 0));
        set_rd(1, 1, 0); cyc(1, pat(16'h2000, 1));
        set_rd(0, 0, 0); cyc(0, '0); cyc(0, '0);

        // commit bank 0 in the same cycle bank 1 is released
        set_wr(1, 0, pat(16'h3000, 0), 4'hF, 0); cyc(0, '0);
        set_wr(1, 1, pat(16'h3000, 1), 4'hF, 1); set_rd(0, 0, 1); cyc(0, '0);
        set_wr(0, 0, '0, 4'h0, 0); set_rd(0, 0, 0);
        flags(1'b1, 1'b1, 2'd1, 1'b0);

        // out-of-range write into bank 1 with commit, out-of-range read of bank 0
        set_wr(1, DEPTH, {4{16'hFFFF}}, 4'hF, 1); cyc(0, '0);
        set_wr(0, 0, '0, 4'h0, 0);
        flags(1'b0, 1'b1, 2'd2, 1'b1);
        set_rd(1, 1, 0);         cyc(1, pat(16'h3000, 1));
        set_rd(1, DEPTH + 5, 0); cyc(1, '0);
        set_rd(1, 0, 1);         cyc(1, pat(16'h3000, 0));
        set_rd(0, 0, 0);
        flags(1'b1, 1'b1, 2'd1, 1'b1);
        set_rd(1, 0, 0); cyc(1, pat(16'h2000, 0));
        set_rd(0, 0, 0); cyc(0, '0); cyc(0, '0);

        // both banks full with a read in flight, then asynchronous reset
        set_wr(1, 2, pat(16'h3000, 2), 4'hF, 1); cyc(0, '0);
        set_wr(0, 0, '0, 4'h0, 0);
        flags(1'b0, 1'b1, 2'd2, 1'b1);
        set_rd(1, 1, 0); cyc(1, pat(16'h2000, 1));
        set_rd(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        flags(1'b1, 1'b0, 2'd0, 1'b0);
        chk_rd();
        #10 rst_n = 1'b1;
        cyc(0, '0);
        flags(1'b1, 1'b0, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
